qei_speed: RTL
==============

QEI_SPEED -- requirements
Module: qei_speed

Interface
REQ-001 Parameter nbits, default 16: width of the QEI position input and of the speed output.
REQ-002 Parameter period, default 48000: sample period in clk cycles, at least 2.
REQ-003 Parameter shift, default 2: IIR filter coefficient exponent, 0 to 7.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port en, input, 1: enable; high runs sampling.
REQ-007 Port clr, input, 1: synchronous clear.
REQ-008 Port pos, input, nbits: free-running QEI position count, two's-complement wrap.
REQ-009 Port speed, output, nbits, signed: counts per sample period.
REQ-010 Port valid, output, 1: one-cycle strobe when speed updates.
REQ-011 Port ovf, output, 1: sticky flag for an ambiguous delta.

Function
REQ-012 Tick counter shall count 0 to period-1 while en=1 and wrap; a sample occurs in the cycle it equals period-1.
REQ-013 The block shall use a state machine with states IDLE, PRIME and RUN.
REQ-014 IDLE shall move to PRIME when en=1; PRIME shall latch pos into prev at the first sample, move to RUN, and leave valid low.
REQ-015 In RUN, each sample shall compute delta = (pos - prev) mod 2^nbits as signed nbits, latch prev <= pos, and assert valid exactly one cycle later with the updated speed.
REQ-016 Wrap-around shall be handled purely by modular subtraction, so 0xFFFE to 0x0003 gives +5.
REQ-017 A delta of exactly -2^(nbits-1) shall set ovf and shall still be output as that value.
REQ-018 en=0 shall zero the tick counter, return the FSM to IDLE, and force valid=0; speed and ovf shall hold.
REQ-019 clr=1 shall zero the tick counter, speed, the filter accumulator and ovf, force valid=0, and go to IDLE; clr has priority over en.
REQ-020 pos shall be sampled only at sample instants; changes between samples shall be ignored.

Reset
REQ-021 With rst=0, speed, valid, ovf, the tick counter, prev and the accumulator shall all be 0 and the FSM shall be in IDLE, regardless of clk.
REQ-022 Release of rst shall start counting on the first rising clk edge with en=1; reset asserted mid-period shall discard the partial period.

Configuration
REQ-023 Macro QEI_SPEED_FILTER_EN.
  - When defined: acc (nbits+shift bits, signed) updates as acc <= acc + delta - (acc >>> shift) at each RUN sample, and speed = acc >>> shift.
  - Steady state shall be exact for a constant delta.
REQ-024 When QEI_SPEED_FILTER_EN is undefined, speed shall equal delta, no accumulator shall exist, and shift shall be ignored.

Structure
REQ-025 State encodings (IDLE/PRIME/RUN) and the default sample period shall live in the shared config header alongside QEI_RES and PWM_RES.
REQ-026 One sub-module, speed_iir (accumulator and shift), shall be instantiated only under QEI_SPEED_FILTER_EN; all other logic shall be inline.

Verification (nbits=16, period=100, shift=2)
REQ-027 Constant pos=0x1000, en=1: first valid at cycle 200, then every 100 cycles, speed=0, ovf=0.
REQ-028 Filter off, pos +5 per period: speed=5. Pos 0xFFFE then 0x0003: speed=+5. Pos 0x0003 then 0xFFFE: speed=-5 (0xFFFB).
REQ-029 Filter on, step delta=8: accumulator 8, 14, ... speed converges to exactly 8 with no residual error.
REQ-030 Pos 0x0000 then 0x8000: ovf=1 and speed=0x8000; ovf stays 1 until clr, and clr clears it.
REQ-031 clr pulse at mid-period: next cycle speed=0, valid=0; the next valid arrives 200 cycles after clr deasserts.
REQ-032 rst low for 3 cycles mid-run, asynchronous to clk: all outputs are 0 immediately; the bench then repeats REQ-027 timing.

Source files
------------

// File: rtl/qei_speed_pkg.sv
// qei_speed_pkg: shared config header for the QEI speed block.
// Holds FSM state encodings, the default sample period and resolution constants.
package qei_speed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int DEFAULT_PERIOD = 48000;
  localparam int QEI_RES        = 16;
  localparam int PWM_RES        = 12;

endpackage

// File: rtl/qei_speed_iir.sv
// speed_iir: first-order IIR smoothing of the per-period position delta.
// The accumulator carries shift extra fraction bits, so a constant delta settles with no residual error.
module speed_iir #(
  parameter int nbits = 16,
  parameter int shift = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    upd,
  input  logic signed [nbits-1:0] delta,
  output logic signed [nbits-1:0] speed
);

  localparam int AW = nbits + shift;

  logic signed [AW-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = clr ? '0 : upd ? acc_q + AW'(delta) - (acc_q >>> shift) : acc_q;
    speed = acc_q[AW-1:shift];
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;

endmodule

// File: rtl/qei_speed.sv
// qei_speed: samples a free-running QEI count every period clocks and reports signed counts per period.
// Define QEI_SPEED_FILTER_EN to smooth the output through speed_iir; otherwise speed is the raw delta.
module qei_speed
  import qei_speed_pkg::*;
#(
  parameter int nbits  = QEI_RES,
  parameter int period = DEFAULT_PERIOD,
  parameter int shift  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [nbits-1:0]        pos,
  output logic signed [nbits-1:0] speed,
  output logic                    valid,
  output logic                    ovf
);

  localparam int                TW        = $clog2(period);
  localparam logic [TW-1:0]     TICK_MAX  = TW'(period - 1);
  localparam logic [nbits-1:0]  DELTA_MIN = {1'b1, {(nbits-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [nbits-1:0]        prev_q, prev_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    sample, latch, upd;
  logic signed [nbits-1:0] delta;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;

  always_comb
    state_d = (clr || !en)                 ? IDLE  :
              (state_q == IDLE)            ? PRIME :
              (state_q == PRIME && sample) ? RUN   : state_q;

  always_comb begin
    sample = en && !clr && tick_q == TICK_MAX;
    latch  = sample && state_q != IDLE;
    upd    = sample && state_q == RUN;
  end

  // Modular subtraction makes counter wrap-around transparent.
  always_comb begin
    tick_d  = (clr || !en || sample) ? '0 : tick_q + TW'(1);
    delta   = pos - prev_q;
    prev_d  = latch ? pos : prev_q;
    valid_d = upd;
    ovf_d   = !clr && (ovf_q || (upd && delta == DELTA_MIN));
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tick_q  <= '0;
      prev_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end

`ifdef QEI_SPEED_FILTER_EN
  speed_iir #(
    .nbits(nbits),
    .shift(shift)
  ) u_iir (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .upd  (upd),
    .delta(delta),
    .speed(speed)
  );
`else
  logic signed [nbits-1:0] speed_q, speed_d;
  logic                    unused_shift;

  assign unused_shift = ^shift;

  always_comb
    speed_d = clr ? '0 : upd ? delta : speed_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) speed_q <= '0;
    else      speed_q <= speed_d;

  assign speed = speed_q;
`endif

  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule
